mod_addsub_sched: RTL

//  Two-requester arbiter and sequencer for the modular adder/subtractor datapath (first stage plus later stages).

---
 rtl/mod_addsub_pkg.sv | 30 +++
 rtl/mod_addsub_sched_rr_arb2.sv | 27 ++
 rtl/mod_addsub_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mod_addsub_pkg.sv
// +-----------------------------------------------------------------------+
// | mod_addsub_pkg                                                        |
// | Shared defaults, FSM state encoding and job record for the scheduler  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package mod_addsub_pkg;

  localparam int W_DEF         = 4;
  localparam int MODULUS_DEF   = 15;
  localparam int STAGE_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic             s;
    logic [W_DEF-1:0] x;
    logic [W_DEF-1:0] y;
    logic             id;
  } job_t;

endpackage

`default_nettype wire

// File: rtl/mod_addsub_sched_rr_arb2.sv
// +-----------------------------------------------------------------------+
// | rr_arb2                                                               |
// | Two-way combinational round-robin grant; pointer lives in the parent  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mod_addsub_sched.sv
// +-----------------------------------------------------------------------+
// | mod_addsub_sched                                                      |
// | Round-robin job sequencer for the modular add/sub datapath.           |
// | Optional operand range check: define MOD_RANGE_CHECK_EN.              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module mod_addsub_sched
  import mod_addsub_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int MODULUS   = MODULUS_DEF,
  parameter int STAGE_LAT = STAGE_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_s,
  input  logic [W-1:0] req0_x,
  input  logic [W-1:0] req0_y,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_s,
  input  logic [W-1:0] req1_x,
  input  logic [W-1:0] req1_y,
  output logic         dp_s,
  output logic [W-1:0] dp_x,
  output logic [W-1:0] dp_y,
  output logic         dp_start,
  input  logic [W-1:0] dp_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic         busy
);

  localparam int CNT_W = $clog2(STAGE_LAT + 1);

  generate
    if (STAGE_LAT < 1 || STAGE_LAT > 15 || MODULUS < 2 || W != W_DEF) begin : g_param_check
      $error("mod_addsub_sched: unsupported parameter set");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  job_t             w_job;
  logic             w_accept;
  logic             w_range_err;
  logic             w_cnt_done;

  assign w_req = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .req  (w_req),
    .last (r_last),
    .gnt  (w_gnt)
  );

  assign w_job = w_gnt[1] ? job_t'{s: req1_s, x: req1_x, y: req1_y, id: 1'b1}
                          : job_t'{s: req0_s, x: req0_x, y: req0_y, id: 1'b0};

`ifdef MOD_RANGE_CHECK_EN
  assign w_range_err = (int'(w_job.x) >= MODULUS) || (int'(w_job.y) >= MODULUS);
`else
  assign w_range_err = 1'b0;
`endif

  // Grants are masked during reset so no job can slip in while rst is high.
  assign w_accept   = (r_state == IDLE) && !rst && (|w_gnt);
  assign w_cnt_done = (r_cnt == CNT_W'(STAGE_LAT));
  assign busy       = (r_state != IDLE);

  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    dp_start   = 1'b0;
    rsp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = w_gnt[0] && !rst;
        req1_ready = w_gnt[1] && !rst;
        if (w_accept) begin
          w_next = w_range_err ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        dp_start = 1'b1;
        w_next   = WAIT;
      end
      WAIT: begin
        if (w_cnt_done) begin
          w_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      dp_s     <= 1'b0;
      dp_x     <= '0;
      dp_y     <= '0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        dp_s    <= w_job.s;
        dp_x    <= w_job.x;
        dp_y    <= w_job.y;
        rsp_id  <= w_job.id;
        r_last  <= w_job.id;
        rsp_err <= w_range_err;
        if (w_range_err) begin
          rsp_data <= '0;
        end
      end
      if (r_state == ISSUE) begin
        r_cnt <= CNT_W'(1);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Operands have been stable for STAGE_LAT cycles, so the result is settled.
      if (r_state == WAIT && w_cnt_done) begin
        rsp_data <= dp_result;
      end
    end
  end

endmodule

`default_nettype wire
